initial_permutation_stream: RTL

//  Applies the DES Initial Permutation (IP) to 64-bit blocks entering the cipher datapath; inverse of the IP^-1 output stage.

---
 rtl/initial_permutation_stream.sv | 94 +++++++++
 1 files changed

// File: rtl/initial_permutation_stream.sv
// DES initial permutation with a small output FIFO and valid/ready handshakes.
// Splits the permuted block into L0/R0 halves for the first round.
module initial_permutation_stream #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             set,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:63]      data_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:63]      data_out,
   output logic [0:31]      l0,
   output logic [0:31]      r0,
   output logic             status,
   output logic [CNT_W-1:0] blk_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } occ_t;

   occ_t          state, state_nxt;
   logic [OW-1:0] cnt, cnt_nxt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [0:63]   mem [DEPTH];
   logic [0:63]   perm;
   logic          push, pop;

   // Bit routing: output byte i takes bit B[i]-8k-1 for each k.
   for (genvar i = 0; i < 8; i++) begin : g_row
      localparam int BI = (i < 4) ? (58 + 2 * i) : (57 + 2 * (i - 4));
      for (genvar k = 0; k < 8; k++) begin : g_col
         assign perm[8*i+k] = data_in[BI-8*k-1];
      end
   end

   assign push      = in_valid & in_ready;
   assign out_valid = (state != EMPTY);
   assign pop       = out_valid & out_ready;

   always_comb begin
      cnt_nxt   = cnt;
      state_nxt = state;
      unique case ({push, pop})
         2'b10:   cnt_nxt = cnt + OW'(1);
         2'b01:   cnt_nxt = cnt - OW'(1);
         default: cnt_nxt = cnt;
      endcase
      unique case (1'b1)
         (cnt_nxt == '0):         state_nxt = EMPTY;
         (cnt_nxt == OW'(DEPTH)): state_nxt = FULL;
         default:                 state_nxt = PARTIAL;
      endcase
   end

   always_ff @(posedge clk or posedge set) begin
      if (set) begin
         state     <= EMPTY;
         cnt       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         in_ready  <= 1'b0;
         blk_count <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         in_ready <= (cnt_nxt < OW'(DEPTH));
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            blk_count <= blk_count + CNT_W'(1);
         end
      end
   end

   // Storage needs no reset; reads are gated by out_valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= perm;
   end

   assign data_out = out_valid ? mem[rd_ptr] : '0;
   assign l0       = data_out[0:31];
   assign r0       = data_out[32:63];
   assign status   = (cnt == '0) & ~push;

endmodule
